// File: rtl/video_pkg.sv
// Shared definitions for the video output stage: RGB565 field positions,
// FSM state encoding and default frame geometry.
package video_pkg;

   localparam int DEFAULT_WIDTH  = 320;
   localparam int DEFAULT_HEIGHT = 240;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                          input logic [4:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/video_stream_source_if.sv
// Pixel input handshake plus Avalon-ST source signals of the video output stage.
interface video_stream_source_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_sof;
   logic              pix_ready;
   logic [DATA_W-1:0] src_data;
   logic              src_valid;
   logic              src_ready;
   logic              src_startofpacket;
   logic              src_endofpacket;

   modport master (
      input  pix_data, pix_valid, pix_sof, src_ready,
      output pix_ready, src_data, src_valid, src_startofpacket, src_endofpacket
   );

   modport slave (
      output pix_data, pix_valid, pix_sof, src_ready,
      input  pix_ready, src_data, src_valid, src_startofpacket, src_endofpacket
   );
endinterface

// File: rtl/video_sync_fifo.sv
// Small show-ahead synchronous FIFO; head entry is visible on dout whenever not empty.
module video_sync_fifo #(
   parameter int W     = 18,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr_reg;
   logic [AW:0]  rd_ptr_reg;

   // Extra pointer bit separates full from empty when the indices coincide.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});
   assign dout  = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end
endmodule

// File: rtl/video_stream_source.sv
// Frame-aligning Avalon-ST video source: tags SOP/EOP, buffers against
// downstream backpressure and reports frame count and truncation errors.
module video_stream_source
   import video_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int HEIGHT     = DEFAULT_HEIGHT,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   video_stream_source_if.master  vid,
   output logic [15:0]            frame_count,
   output logic                   frame_error,
   output logic                   busy
);
   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   state_t            state_reg;
   logic [XW-1:0]     x_reg;
   logic [YW-1:0]     y_reg;
   logic [15:0]       frame_count_reg;
   logic              frame_error_reg;

   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W+1:0] fifo_din;
   logic [DATA_W+1:0] fifo_dout;
   logic              accept;
   logic              at_origin;
   logic              push;
   logic              pop;
   logic              eop_bit;
   logic [XW-1:0]     px;
   logic [YW-1:0]     py;

   // A sof pixel always sits at (0,0), even when it truncates a frame.
   always_comb begin
      at_origin = (x_reg == '0) && (y_reg == '0);
      px        = vid.pix_sof ? '0 : x_reg;
      py        = vid.pix_sof ? '0 : y_reg;
      eop_bit   = (px == X_LAST) && (py == Y_LAST);
      accept    = vid.pix_valid && !fifo_full;
      fifo_din  = {vid.pix_sof, eop_bit, vid.pix_data};
      push      = 1'b0;
      if (state_reg == S_IDLE) begin
         push = accept && enable && vid.pix_sof;
      end else begin
         push = accept && (vid.pix_sof || !at_origin);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_IDLE;
         x_reg           <= '0;
         y_reg           <= '0;
         frame_count_reg <= '0;
         frame_error_reg <= 1'b0;
      end else begin
         if (push) begin
            if (eop_bit) begin
               x_reg     <= '0;
               y_reg     <= '0;
               state_reg <= enable ? S_STREAM : S_IDLE;
            end else begin
               state_reg <= S_STREAM;
               if (px == X_LAST) begin
                  x_reg <= '0;
                  y_reg <= py + 1'b1;
               end else begin
                  x_reg <= px + 1'b1;
                  y_reg <= py;
               end
            end
            if ((state_reg == S_STREAM) && vid.pix_sof && !at_origin) begin
               frame_error_reg <= 1'b1;
            end
         end
         if (pop && vid.src_endofpacket) begin
            frame_count_reg <= frame_count_reg + 1'b1;
         end
      end
   end

   video_sync_fifo #(
      .W     (DATA_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head entry is masked to zero while empty so the bus idles clean.
   assign {vid.src_startofpacket, vid.src_endofpacket, vid.src_data} =
      fifo_empty ? '0 : fifo_dout;
   assign vid.src_valid = !fifo_empty;
   assign vid.pix_ready = !fifo_full;
   assign pop           = !fifo_empty && vid.src_ready;
   assign busy          = (state_reg != S_IDLE) || !fifo_empty;
   assign frame_count   = frame_count_reg;
   assign frame_error   = frame_error_reg;
endmodule

// File: tb/tb_video_stream_source.sv
// Directed scoreboard bench for video_stream_source with a 4x2 frame and 4-deep FIFO.
`timescale 1ns/1ps
module tb_video_stream_source;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] frame_count;
   logic        frame_error;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [17:0] sb[$];
   logic [17:0] cur;
   logic [17:0] held;
   bit          stalled = 0;

   video_stream_source_if #(.DATA_W(16)) vif();

   video_stream_source #(
      .WIDTH(4), .HEIGHT(2), .DATA_W(16), .FIFO_DEPTH(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .vid         (vif.master),
      .frame_count (frame_count),
      .frame_error (frame_error),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: scoreboard pops on transfer, hold check while stalled.
   always @(negedge clk) begin
      cur = {vif.src_startofpacket, vif.src_endofpacket, vif.src_data};
      if (!reset) begin
         stalled = 0;
      end else begin
         if (stalled) chk("hold_stable", 32'(cur), 32'(held));
         if (vif.src_valid && vif.src_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_beat", 32'(sb.size()), 32'd1);
            end else begin
               logic [17:0] e;
               e = sb.pop_front();
               chk("beat", 32'(cur), 32'(e));
               $display("beat data=%04h sop=%0b eop=%0b", vif.src_data,
                        vif.src_startofpacket, vif.src_endofpacket);
            end
         end
         stalled = vif.src_valid && !vif.src_ready;
         held    = cur;
      end
   end

   task automatic send(input logic [15:0] d, input logic sof, input logic eop, input bit counted);
      int   n;
      logic rdy;
      n = 0;
      vif.pix_data  = d;
      vif.pix_valid = 1'b1;
      vif.pix_sof   = sof;
      if (counted) sb.push_back({sof, eop, d});
      do begin
         @(negedge clk);
         rdy = vif.pix_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 50);
      if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
      vif.pix_valid = 1'b0;
      vif.pix_sof   = 1'b0;
   endtask

   task automatic frame(input logic [15:0] base);
      for (int i = 0; i < 8; i++) send(base + 16'(i), i == 0, i == 7, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((sb.size() != 0 || vif.src_valid) && n < 200);
      if (n >= 200) chk("drain_timeout", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vif.pix_data  = '0;
      vif.pix_valid = 1'b0;
      vif.pix_sof   = 1'b0;
      vif.src_ready = 1'b1;
      #3;
      chk("rst_src_valid", 32'(vif.src_valid), 0);
      chk("rst_sop", 32'(vif.src_startofpacket), 0);
      chk("rst_eop", 32'(vif.src_endofpacket), 0);
      chk("rst_data", 32'(vif.src_data), 0);
      chk("rst_frame_count", 32'(frame_count), 0);
      chk("rst_frame_error", 32'(frame_error), 0);
      chk("rst_busy", 32'(busy), 0);
      @(posedge clk); #1;
      reset  = 1'b1;
      enable = 1'b1;

      // Continuous frame
      frame(16'h0001);
      drain();
      chk("t1_frame_count", 32'(frame_count), 1);
      chk("t1_frame_error", 32'(frame_error), 0);

      // Backpressure
      vif.src_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'h0011 + 16'(i), i == 0, 1'b0, 1);
      vif.pix_data  = 16'h0015;
      vif.pix_valid = 1'b1;
      @(negedge clk);
      chk("t2_pix_ready_full", 32'(vif.pix_ready), 0);
      chk("t2_head_sop", 32'({vif.src_startofpacket, vif.src_data}), 32'h10011);
      repeat (9) @(posedge clk);
      #1;
      vif.src_ready = 1'b1;
      for (int i = 4; i < 8; i++) send(16'h0011 + 16'(i), 1'b0, i == 7, 1);
      drain();
      chk("t2_frame_count", 32'(frame_count), 2);

      // Pre-sync drop
      for (int i = 0; i < 3; i++) send(16'h00A0 + 16'(i), 1'b0, 1'b0, 0);
      frame(16'h0021);
      drain();
      chk("t3_frame_count", 32'(frame_count), 3);
      chk("t3_frame_error", 32'(frame_error), 0);

      // Truncation by early sof
      for (int i = 0; i < 4; i++) send(16'h0031 + 16'(i), i == 0, 1'b0, 1);
      frame(16'h0035);
      drain();
      chk("t4_frame_error", 32'(frame_error), 1);
      chk("t4_frame_count", 32'(frame_count), 4);

      // Enable drop mid-frame
      for (int i = 0; i < 8; i++) begin
         if (i == 2) enable = 1'b0;
         send(16'h0041 + 16'(i), i == 0, i == 7, 1);
      end
      drain();
      chk("t5_busy_idle", 32'(busy), 0);
      send(16'h0051, 1'b1, 1'b0, 0);
      send(16'h0052, 1'b0, 1'b0, 0);
      drain();
      chk("t5_busy_after_drop", 32'(busy), 0);
      chk("t5_frame_count", 32'(frame_count), 5);

      // Async reset mid-frame, between clock edges
      enable = 1'b1;
      vif.src_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'h0061 + 16'(i), i == 0, 1'b0, 1);
      chk("t6_valid_before_rst", 32'(vif.src_valid), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_src_valid", 32'(vif.src_valid), 0);
      chk("t6_rst_frame_count", 32'(frame_count), 0);
      chk("t6_rst_frame_error", 32'(frame_error), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_data", 32'(vif.src_data), 0);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      vif.src_ready = 1'b1;
      frame(16'h0071);
      drain();
      chk("t6_frame_count", 32'(frame_count), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
